// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - write-side port bundle for uart_tx_param
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 10
);
    logic [DATA_BITS-1:0] din;
    logic                 wr_en;
    logic                 full;
    logic                 overflow;
    logic [CNT_W-1:0]     data_count;

    modport master (
        output din,
        output wr_en,
        input  full,
        input  overflow,
        input  data_count
    );

    modport slave (
        input  din,
        input  wr_en,
        output full,
        output overflow,
        output data_count
    );
endinterface

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - UART transmitter with byte FIFO, runtime divisor, parity and stop selection
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 512,
    parameter int DIV_W     = 16,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             srst,
    uart_tx_param_if.slave   wr,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    output logic             TX,
    output logic             busy,
    output logic             tx_done
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t state;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shreg;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     cnt;
    logic [3:0]           idx;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 two_stop_q;
    logic                 full_w;
    logic                 wr_acc;
    logic                 bit_last;
    logic                 last_stop;
    logic                 frame_end;
    logic                 pop;

    assign full_w    = (count == DEPTH_C);
    assign wr_acc    = wr.wr_en && !full_w;
    assign head      = mem[rd_ptr];
    assign bit_last  = (cnt == div_q - 1'b1);
    assign last_stop = (idx == {3'b000, two_stop_q});
    assign frame_end = (state == S_STOP) && bit_last && last_stop;
    // The next frame is popped in the final stop cycle so frames abut with no idle gap.
    assign pop       = (count != '0) && ((state == S_IDLE) || frame_end);

    assign wr.full       = full_w;
    assign wr.overflow   = wr.wr_en && full_w;
    assign wr.data_count = count;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(wr_acc) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !srst) mem[wr_ptr] <= wr.din;
    end

    // tx_done is registered, so it is raised on the edge that enters the final stop cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= S_IDLE;
            TX         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            div_q      <= DIV_ONE;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                state      <= S_START;
                TX         <= 1'b0;
                busy       <= 1'b1;
                cnt        <= '0;
                idx        <= '0;
                shreg      <= head;
                div_q      <= (baud_div == '0) ? DIV_ONE : baud_div;
                par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit_q  <= (^head) ^ (parity_mode == 2'b10);
                two_stop_q <= two_stop;
            end else begin
                case (state)
                    S_IDLE: begin
                        TX   <= 1'b1;
                        busy <= 1'b0;
                    end
                    S_START: begin
                        if (bit_last) begin
                            state <= S_DATA;
                            TX    <= shreg[0];
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (bit_last) begin
                            cnt <= '0;
                            if (idx == LAST_BIT) begin
                                idx <= '0;
                                if (par_en_q) begin
                                    state <= S_PARITY;
                                    TX    <= par_bit_q;
                                end else begin
                                    state   <= S_STOP;
                                    TX      <= 1'b1;
                                    tx_done <= (div_q == DIV_ONE) && !two_stop_q;
                                end
                            end else begin
                                idx   <= idx + 1'b1;
                                shreg <= shreg >> 1;
                                TX    <= shreg[1];
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (bit_last) begin
                            state   <= S_STOP;
                            TX      <= 1'b1;
                            cnt     <= '0;
                            tx_done <= (div_q == DIV_ONE) && !two_stop_q;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (bit_last) begin
                            if (last_stop) begin
                                state <= S_IDLE;
                                TX    <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                idx     <= idx + 1'b1;
                                cnt     <= '0;
                                tx_done <= (div_q == DIV_ONE);
                            end
                        end else begin
                            cnt     <= cnt + 1'b1;
                            tx_done <= last_stop && (cnt + 1'b1 == div_q - 1'b1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - randomized and directed checks of uart_tx_param against a frame-level model
`timescale 1ns/1ps
module tb_uart_tx_param;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             srst = 1'b1;
    logic [DIV_W-1:0] baud_div = 16'd4;
    logic [1:0]       parity_mode = 2'b00;
    logic             two_stop = 1'b0;
    logic             TX, busy, tx_done;
    logic             tx5, busy5, done5;
    logic             tx9, busy9, done9;

    int tests = 0;
    int fails = 0;
    int prints = 0;

    uart_tx_param_if #(.DATA_BITS(DB), .CNT_W(CNT_W)) wif ();
    uart_tx_param_if #(.DATA_BITS(5), .CNT_W(2)) wif5 ();
    uart_tx_param_if #(.DATA_BITS(9), .CNT_W(2)) wif9 ();

    uart_tx_param #(.DATA_BITS(DB), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .srst(srst), .wr(wif), .baud_div(baud_div), .parity_mode(parity_mode),
        .two_stop(two_stop), .TX(TX), .busy(busy), .tx_done(tx_done)
    );
    uart_tx_param #(.DATA_BITS(5), .DEPTH(2), .DIV_W(DIV_W)) dut5 (
        .clk(clk), .srst(srst), .wr(wif5), .baud_div(16'd2), .parity_mode(2'b00),
        .two_stop(1'b0), .TX(tx5), .busy(busy5), .tx_done(done5)
    );
    uart_tx_param #(.DATA_BITS(9), .DEPTH(2), .DIV_W(DIV_W)) dut9 (
        .clk(clk), .srst(srst), .wr(wif9), .baud_div(16'd2), .parity_mode(2'b00),
        .two_stop(1'b0), .TX(tx9), .busy(busy9), .tx_done(done9)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (prints < 40) begin
                prints++;
                $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
            end
        end
    endtask

    // Model: FIFO contents plus the remaining per-cycle line samples {done, tx} of the frame in flight.
    logic [DB-1:0] mfifo[$];
    logic [1:0]    mline[$];
    bit            mvalid = 0;

    task automatic push_frame(input logic [DB-1:0] d, input logic [DIV_W-1:0] bd,
                              input logic [1:0] pm, input logic ts);
        int   div;
        logic bits[$];
        div = (bd == 0) ? 1 : int'(bd);
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (pm == 2'b01) bits.push_back(^d);
        else if (pm == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++)
            for (int c = 0; c < div; c++)
                mline.push_back({(i == bits.size() - 1) && (c == div - 1), bits[i]});
    endtask

    initial begin : model_proc
        bit            do_pop, do_wr;
        logic [DB-1:0] hd;
        forever begin
            @(posedge clk);
            if (srst) begin
                mfifo.delete();
                mline.delete();
                mvalid = 1;
            end else begin
                do_pop = (mfifo.size() != 0) && (mline.size() <= 1);
                do_wr  = wif.wr_en && (mfifo.size() < DEPTH);
                if (mline.size() != 0) void'(mline.pop_front());
                if (do_pop) begin
                    hd = mfifo.pop_front();
                    push_frame(hd, baud_div, parity_mode, two_stop);
                end
                if (do_wr) mfifo.push_back(wif.din);
            end
        end
    end

    initial begin : compare_proc
        logic [1:0] h;
        logic [7:0] got, exp;
        forever begin
            @(negedge clk);
            if (mvalid) begin
                h   = (mline.size() != 0) ? mline[0] : 2'b01;
                got = {TX, busy, tx_done, wif.full, wif.overflow, wif.data_count};
                exp = {h[0], mline.size() != 0, h[1], mfifo.size() == DEPTH,
                       wif.wr_en && (mfifo.size() == DEPTH), CNT_W'(mfifo.size())};
                chk("cycle", 32'(got), 32'(exp));
            end
        end
    end

    logic samp[$];

    function automatic logic [31:0] bits_of(input int div, input int nb);
        logic [31:0] r = '0;
        for (int i = 0; i < nb; i++)
            if (i * div < samp.size()) r[i] = samp[i * div];
        return r;
    endfunction

    task automatic send_one(input logic [7:0] d, input logic [15:0] bd, input logic [1:0] pm,
                            input logic ts, output int len);
        int n;
        bit seen;
        samp.delete();
        baud_div = bd; parity_mode = pm; two_stop = ts;
        wif.din = d; wif.wr_en = 1'b1;
        @(posedge clk); #1 wif.wr_en = 1'b0;
        n = 0; seen = 0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (busy) begin
                samp.push_back(TX);
                n++;
                if (tx_done) seen = 1;
            end
        end
        chk("frame_end_seen", 32'(seen), 1);
        len = n;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          len, t, d1, d2, dones;
        bit          bad;
        logic [31:0] v;
        logic        s5[$], s9[$];
        bit          f5, f9;

        wif.din = '0; wif.wr_en = 1'b0;
        wif5.din = '0; wif5.wr_en = 1'b0;
        wif9.din = '0; wif9.wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        chk("rst_tx", 32'(TX), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_count", 32'(wif.data_count), 0);
        chk("rst_full", 32'(wif.full), 0);

        send_one(8'h55, 16'd4, 2'b00, 1'b0, len);
        chk("8n1_len", 32'(len), 40);
        chk("8n1_bits", bits_of(4, 10), 32'h2AA);
        @(negedge clk);
        chk("8n1_idle_after", 32'(busy), 0);

        send_one(8'h03, 16'd2, 2'b01, 1'b0, len);
        v = bits_of(2, 11);
        chk("even_len", 32'(len), 22);
        chk("even_parity_bit", 32'(v[9]), 0);
        chk("even_bits", v, 32'h406);
        send_one(8'h03, 16'd2, 2'b10, 1'b0, len);
        v = bits_of(2, 11);
        chk("odd_parity_bit", 32'(v[9]), 1);
        chk("odd_bits", v, 32'h606);
        send_one(8'h03, 16'd2, 2'b01, 1'b1, len);
        chk("two_stop_len", 32'(len), 24);
        chk("two_stop_bits", bits_of(2, 12), 32'hC06);

        send_one(8'h55, 16'd0, 2'b00, 1'b0, len);
        chk("div0_len", 32'(len), 10);
        chk("div0_bits", bits_of(1, 10), 32'h2AA);
        send_one(8'h55, 16'd1, 2'b00, 1'b0, len);
        chk("div1_len", 32'(len), 10);
        send_one(8'hA5, 16'd3, 2'b11, 1'b0, len);
        chk("pm11_len", 32'(len), 30);

        // Divisor changed after the first frame has latched it.
        @(negedge clk);
        baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
        wif.din = 8'h12; wif.wr_en = 1'b1;
        @(posedge clk); #1 wif.din = 8'h34;
        @(posedge clk); #1 wif.wr_en = 1'b0; baud_div = 16'd8;
        t = 0; d1 = 0; d2 = 0;
        for (int c = 0; c < 400 && d2 == 0; c++) begin
            @(negedge clk);
            t++;
            if (tx_done) begin
                if (d1 == 0) d1 = t; else d2 = t;
            end
        end
        chk("div_change_first", 32'(d1), 40);
        chk("div_change_second", 32'(d2), 120);

        // Back-to-back with the FIFO filled to overflow.
        @(posedge clk); #1;
        baud_div = 16'd2;
        wif.din = 8'h11; wif.wr_en = 1'b1;
        @(posedge clk); #1 wif.wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            wif.din = 8'(8'hA0 + i); wif.wr_en = 1'b1;
            @(negedge clk);
            if (i == 3) chk("not_full_4th", 32'(wif.full), 0);
            if (i == 4) begin
                chk("full_5th", 32'(wif.full), 1);
                chk("overflow_5th", 32'(wif.overflow), 1);
            end
            @(posedge clk); #1;
        end
        wif.wr_en = 1'b0;
        dones = 0;
        for (int c = 0; c < 600 && (busy || c < 2); c++) begin
            @(negedge clk);
            if (tx_done) dones++;
        end
        chk("b2b_frames", 32'(dones), 5);

        // Reset in the middle of a data bit with three frames queued.
        @(posedge clk); #1;
        baud_div = 16'd3;
        for (int i = 0; i < 4; i++) begin
            wif.din = 8'(8'h21 + i); wif.wr_en = 1'b1;
            @(posedge clk); #1;
        end
        wif.wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_count", 32'(wif.data_count), 3);
        srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", 32'(TX), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_count", 32'(wif.data_count), 0);
        chk("mid_rst_done", 32'(tx_done), 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_done || busy || !TX) bad = 1;
        end
        chk("post_rst_quiet", 32'(bad), 0);
        send_one(8'h0F, 16'd4, 2'b00, 1'b0, len);
        chk("post_rst_len", 32'(len), 40);
        chk("post_rst_bits", bits_of(4, 10), 32'h21E);

        // Narrow and wide payload builds.
        @(negedge clk);
        wif5.din = 5'h1F; wif5.wr_en = 1'b1;
        wif9.din = 9'h1AA; wif9.wr_en = 1'b1;
        @(posedge clk); #1 wif5.wr_en = 1'b0; wif9.wr_en = 1'b0;
        f5 = 0; f9 = 0;
        for (int c = 0; c < 200 && !(f5 && f9); c++) begin
            @(negedge clk);
            if (busy5 && !f5) begin s5.push_back(tx5); if (done5) f5 = 1; end
            if (busy9 && !f9) begin s9.push_back(tx9); if (done9) f9 = 1; end
        end
        chk("w5_len", 32'(s5.size()), 14);
        chk("w9_len", 32'(s9.size()), 22);
        samp = s5;
        chk("w5_bits", bits_of(2, 7), 32'h7E);
        samp = s9;
        chk("w9_bits", bits_of(2, 11), 32'h754);

        // Randomized traffic with mid-frame configuration changes and occasional resets.
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            wif.wr_en = ($urandom_range(0, 99) < 35);
            wif.din   = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                baud_div    = 16'($urandom_range(0, 3));
                parity_mode = 2'($urandom);
                two_stop    = 1'($urandom);
            end
            srst = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
        end
        srst = 1'b0;
        wif.wr_en = 1'b0;
        repeat (200) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an integrated byte FIFO, configurable data width, runtime baud divisor, optional parity and one or two stop bits. It sits between any byte producer (command/debug logic) and the board TX pin. It supersedes the fixed 8N1 transmitter:
- bit periods are exact;
- reset is real;
- FIFO overflow is reported;
- frame format is selectable per frame.

## Interface
Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- DEPTH, 512, FIFO entries; power of two, at least 2.
- DIV_W, 16, width of the baud divisor.
- CNT_W, $clog2(DEPTH)+1, width of data_count (derived; do not override).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- srst  in  1  synchronous active-high reset.
- din  in  DATA_BITS  payload to enqueue.
- wr_en  in  1  enqueue din this cycle.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  one-cycle pulse when wr_en arrives while full.
- data_count  out  CNT_W  entries in FIFO; excludes the frame being shifted.
- baud_div  in  DIV_W  clk cycles per bit; 0 is treated as 1.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- two_stop  in  1  0 = one stop bit, 1 = two stop bits.
- TX  out  1  serial line; idle high.
- busy  out  1  high while a frame is on the line.
- tx_done  out  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
FIFO:
- A write is accepted when wr_en=1 and full=0.
- With wr_en=1 and full=1, din is dropped, FIFO contents are unchanged, and overflow=1 for that cycle.
- A simultaneous accepted write and pop leaves data_count unchanged.
- Pointers wrap modulo DEPTH. data_count is the exact occupancy.

Configuration:
- baud_div, parity_mode and two_stop are latched when a frame starts, i.e. on the pop.
- Changing them mid-frame has no effect until the next frame.

State machine (IDLE, START, DATA, PARITY, STOP):
- IDLE:
  - TX=1, busy=0.
  - If the FIFO is non-empty: pop the head into the shifter, latch config, set TX=0, go to START.
- START: hold TX=0 for div cycles, then drive bit 0 and go to DATA.
- DATA:
  - Send DATA_BITS bits, LSB first, each held div cycles.
  - After the last data bit, go to PARITY if parity is enabled, else to STOP.
- PARITY:
  - Even: the parity bit is the XOR of the payload.
  - Odd: the parity bit is its inverse.
  - Hold for div cycles.
- STOP:
  - TX=1 for div cycles (one stop bit) or 2*div cycles (two stop bits).
  - In the final cycle, tx_done=1.
  - If the FIFO is non-empty, pop in that same cycle and enter START on the next edge. There is no idle gap between frames.
  - Otherwise go to IDLE.

Arithmetic:
- div = (baud_div==0) ? 1 : baud_div.
- The bit counter is DIV_W bits and counts 0..div-1. The bit period is exactly div cycles, with no +1.
- The bit index counter is 4 bits.

busy: 1 in every state except IDLE.

## Timing
- Reset (srst high at an edge), effective at that edge:
  - TX=1, busy=0, tx_done=0, overflow=0, full=0, data_count=0.
  - FIFO emptied; state IDLE.
- Reset mid-frame aborts the frame. TX returns high after that edge, and no tx_done is issued.
- Write latency: wr_en sampled at edge k gives data_count+1 after edge k.
- Start latency: if IDLE with the FIFO empty at k, the pop and TX falling occur at edge k+1.
- Frame length in cycles: div*(1 + DATA_BITS + P + S), where P = 1 if parity is enabled else 0, and S = 1 or 2.
- tx_done asserts in cycle n of the frame, where n is the frame length and cycle 1 is the first start-bit cycle.
- full asserts after the edge at which the write makes the count equal DEPTH. It deasserts after the edge of the next pop.
- TX is registered and glitch-free. No combinational path runs from any input to TX.

## Test plan
- Basic 8N1:
  - Stimulus: baud_div=4, parity none, one stop, write 0x55.
  - Response: TX low 4 cycles, then 1,0,1,0,1,0,1,0 with 4 cycles each, then high 4 cycles. tx_done at cycle 40. busy high for cycles 1..40.
- Parity/stop:
  - Stimulus: baud_div=2, write 0x03 with even parity.
  - Response: parity bit = 0. The same byte with odd parity gives parity bit = 1.
  - Stimulus: two_stop=1.
  - Response: stop time = 4 cycles, frame = 24 cycles.
- Back-to-back/full:
  - Stimulus: DEPTH=4, 5 consecutive writes 0xA0..0xA4 while the first frame is already shifting.
  - Response: full asserted after the fourth queued entry. The last write produces overflow=1 and 0xA4 is never sent. Frames follow with zero idle cycles between stop and start bits.
- Divisor edge:
  - Stimulus: baud_div=0 and baud_div=1.
  - Response: both give a 10-cycle 8N1 frame.
  - Stimulus: baud_div changed from 4 to 8 mid-frame.
  - Response: the current frame keeps 4, the next frame uses 8.
- Reset mid-frame:
  - Stimulus: assert srst during DATA with 3 entries queued.
  - Response: after the edge, TX=1, data_count=0, busy=0, no tx_done. A subsequent write of 0x0F transmits cleanly.
- DATA_BITS=5 and DATA_BITS=9 builds:
  - Stimulus: write 0x1F and 0x1AA respectively.
  - Response: exactly 5 and 9 data bits, LSB first.
